// File: rtl/jk_flipflop_pkg.sv
// Shared JK encodings and the per-bit next-state rule.
// {j,k} is the op code of each cell.
package jk_flipflop_pkg;

    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] TOGGLE = 2'b11;

    // Unknown op codes propagate X so bad inputs stay visible.
    function automatic logic jk_next(
        input logic [1:0] op,
        input logic       cur
    );
        logic nxt;
        nxt = 1'bx;
        case (op)
            HOLD:    nxt = cur;
            RESET:   nxt = 1'b0;
            SET:     nxt = 1'b1;
            TOGGLE:  nxt = ~cur;
            default: nxt = 1'bx;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_flipflop_cell.sv
// Single JK storage cell: next-state decode plus one register.
// Synchronous active-high reset loads RST_VAL.
module jk_flipflop_cell
    import jk_flipflop_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = jk_next({j, k}, q_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_flipflop.sv
// WIDTH-bit bank of independent JK cells with a shared clock/reset.
// q_n is derived from q so the pair is always complementary.
module jk_flipflop
    import jk_flipflop_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_flipflop_cell #(
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i])
        );
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_jk_flipflop.sv
// Randomised bench for jk_flipflop: a 1-bit and a 4-bit bank
// checked against a truth-table model.
module tb_jk_flipflop;

    localparam logic [3:0] RV4 = 4'b1010;

    logic       clk = 1'b0;
    logic       rst1 = 1'b0;
    logic       rst4 = 1'b0;
    logic [0:0] j1 = '0, k1 = '0, q1, qn1;
    logic [3:0] j4 = '0, k4 = '0, q4, qn4;

    int total = 0;
    int bad = 0;

    logic [0:0] m1;
    logic [3:0] m4;
    bit         known1 = 0;
    bit         known4 = 0;

    always #5 clk = ~clk;

    jk_flipflop u_dut1 (
        .clk (clk),
        .rst (rst1),
        .j   (j1),
        .k   (k1),
        .q   (q1),
        .q_n (qn1)
    );

    jk_flipflop #(
        .WIDTH   (4),
        .RST_VAL (RV4)
    ) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .j   (j4),
        .k   (k4),
        .q   (q4),
        .q_n (qn4)
    );

    task automatic chk(
        input string      tag,
        input logic [3:0] got,
        input logic [3:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Truth table per bit: {j,k} -> 0 hold, 1 clear, 2 set, 3 invert.
    function automatic logic jk_rule(input logic jb, kb, cur);
        logic [1:0] sel;
        sel = {jb, kb};
        if (sel == 2'd0) return cur;
        if (sel == 2'd1) return 1'b0;
        if (sel == 2'd2) return 1'b1;
        return !cur;
    endfunction

    // Called at posedge+1; drives at +2, checks hold at +4, then
    // applies the edge and checks at the following posedge+1.
    task automatic cycle(
        input logic       r1,
        input logic       jv1,
        input logic       kv1,
        input logic       r4,
        input logic [3:0] jv4,
        input logic [3:0] kv4
    );
        #1;
        rst1 = r1; j1 = jv1; k1 = kv1;
        rst4 = r4; j4 = jv4; k4 = kv4;
        #2;
        if (known1) chk("hold1", {3'b0, q1}, {3'b0, m1});
        if (known4) chk("hold4", q4, m4);
        @(posedge clk);
        if (r1) begin
            m1 = 1'b0;
            known1 = 1;
        end else begin
            m1[0] = jk_rule(jv1, kv1, m1[0]);
        end
        if (r4) begin
            m4 = RV4;
            known4 = 1;
        end else begin
            for (int i = 0; i < 4; i++)
                m4[i] = jk_rule(jv4[i], kv4[i], m4[i]);
        end
        #1;
        if (known1) begin
            chk("q1", {3'b0, q1}, {3'b0, m1});
            chk("qn1", {3'b0, qn1}, {3'b0, ~m1});
        end
        if (known4) begin
            chk("q4", q4, m4);
            chk("qn4", qn4, ~m4);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset with j=k=1: no toggling while held in reset
        cycle(1, 1, 1, 1, 4'hf, 4'hf);
        chk("rst1_lit", {3'b0, q1}, 4'b0000);
        chk("rst4_lit", q4, RV4);
        cycle(1, 1, 1, 1, 4'hf, 4'hf);
        // directed WIDTH=1 sequence
        cycle(0, 0, 0, 0, 4'h0, 4'h0);
        cycle(0, 0, 1, 0, 4'h0, 4'h0);
        cycle(0, 0, 1, 0, 4'h0, 4'h0);
        cycle(0, 1, 0, 0, 4'h0, 4'h0);
        cycle(0, 1, 0, 0, 4'h0, 4'h0);
        cycle(0, 1, 1, 0, 4'h0, 4'h0);
        cycle(0, 1, 1, 0, 4'h0, 4'h0);
        // toggle run from 0
        cycle(0, 0, 1, 0, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 1, 0, 4'h0, 4'h0);
            chk("tog_lit", {3'b0, q1}, (i % 2 == 0) ? 4'd1 : 4'd0);
        end
        // reset mid-toggle with q=1, then resume
        cycle(0, 1, 1, 0, 4'h0, 4'h0);
        cycle(1, 1, 1, 0, 4'h0, 4'h0);
        chk("midrst", {3'b0, q1}, 4'd0);
        cycle(0, 1, 1, 0, 4'h0, 4'h0);
        chk("resume", {3'b0, q1}, 4'd1);
        // vector: reset, then toggle/set/clear/hold across bits
        cycle(0, 0, 0, 1, 4'hf, 4'hf);
        chk("vrst", q4, RV4);
        cycle(0, 0, 0, 0, 4'b0011, 4'b0101);
        chk("vmix", q4, 4'b1011);
        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 15) == 0),
                  1'($urandom), 1'($urandom),
                  ($urandom_range(0, 15) == 0),
                  4'($urandom), 4'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
